bip_run_ctrl: RTL and testbench

Run/load sequencer for the accumulator CPU, sitting between the host command interface and the `control_top`/datapath pair. It owns the instruction-memory write port during program load and holds the CPU in reset while loading. It gates CPU execution through a clock enable, in either free-run or single-step mode. It detects halt from the decoder's `h_flg`, and reports completion, an executed-cycle count and, optionally, a watchdog timeout.

---
 rtl/bip_run_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_bip_run_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_run_ctrl.sv
// -----------------------------------------------------------------------------
// bip_run_ctrl
//
// Run/load sequencer for the accumulator CPU. Sits between the host command
// interface and the control_top/datapath pair:
//   - owns the instruction-memory write port during program load and holds
//     the CPU in reset while loading,
//   - gates CPU execution through o_cpu_en in free-run (RUN) or single-step
//     (STEP) mode,
//   - detects halt from the decoder's h_flg (i_halt),
//   - reports completion (o_done), an executed-cycle count (o_cycles) and,
//     when built with BIP_WATCHDOG_EN, a sticky watchdog timeout (o_timeout).
//
// Optional feature macro: BIP_WATCHDOG_EN (watchdog run counter, WD_LIMIT).
//
// Ports:
//   i_clk, i_rst                 clock (rising edge), synchronous active-high reset
//   i_cmd_valid, i_cmd           command strobe / code (00 LOAD, 01 RUN,
//                                10 STEP, 11 ABORT)
//   o_cmd_ready                  command accept (low only in STEP)
//   i_ld_valid, i_ld_word,       load word strobe / data / final-word marker
//   i_ld_last, o_ld_ready
//   i_halt                       h_flg from control_top (combinational)
//   o_cpu_en, o_cpu_rst          CPU/PC enable, CPU reset
//   o_imem_we, o_imem_addr,      instruction-memory write port
//   o_imem_wdata
//   o_state                      registered FSM state
//   o_cycles                     saturating executed-cycle counter
//   o_done                       one-cycle registered completion pulse
//   o_timeout                    sticky watchdog flag (0 without watchdog)
// -----------------------------------------------------------------------------
module bip_run_ctrl #(
    parameter int BITS     = 16,
    parameter int ADDR     = BITS - 5,
    parameter int WD_LIMIT = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    input  logic [1:0]        i_cmd,
    output logic              o_cmd_ready,
    input  logic              i_ld_valid,
    input  logic [BITS-1:0]   i_ld_word,
    input  logic              i_ld_last,
    output logic              o_ld_ready,
    input  logic              i_halt,
    output logic              o_cpu_en,
    output logic              o_cpu_rst,
    output logic              o_imem_we,
    output logic [ADDR-1:0]   o_imem_addr,
    output logic [BITS-1:0]   o_imem_wdata,
    output logic [2:0]        o_state,
    output logic [31:0]       o_cycles,
    output logic              o_done,
    output logic              o_timeout
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_STEP = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [1:0] CMD_LOAD  = 2'b00;
    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_ABORT = 2'b11;

    state_t            state, next_state;
    logic [ADDR-1:0]   ld_addr;
    logic [31:0]       cycles;
    logic              done_q;
    logic              cmd_acc;
    logic              done_set;   // completion pulse for the next cycle
    logic              load_clr;   // LOAD accepted: clear address/counters/flags
    logic              run_start;  // RUN accepted from IDLE

`ifdef BIP_WATCHDOG_EN
    localparam int                WD_W    = $clog2(WD_LIMIT + 1);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(WD_LIMIT - 1);
    logic [WD_W-1:0]   wd_cnt;
    logic              timeout_q;
    logic              timeout_set;
`endif

    assign o_cmd_ready  = (state != S_STEP);
    assign cmd_acc      = i_cmd_valid & o_cmd_ready;
    assign o_imem_addr  = ld_addr;
    assign o_imem_wdata = i_ld_word;
    assign o_state      = state;
    assign o_cycles     = cycles;
    assign o_done       = done_q;

    // Next-state and Moore/Mealy outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned, which would otherwise infer a latch.
        next_state = state;
        o_ld_ready = 1'b0;
        o_imem_we  = 1'b0;
        o_cpu_en   = 1'b0;
        o_cpu_rst  = 1'b0;
        done_set   = 1'b0;
        load_clr   = 1'b0;
        run_start  = 1'b0;
`ifdef BIP_WATCHDOG_EN
        timeout_set = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                if (cmd_acc) begin
                    unique case (i_cmd)
                        CMD_LOAD: begin
                            next_state = S_LOAD;
                            load_clr   = 1'b1;
                        end
                        CMD_RUN: begin
                            next_state = S_RUN;
                            run_start  = 1'b1;
                        end
                        CMD_STEP:  next_state = S_STEP;
                        default:   ;  // ABORT ignored
                    endcase
                end
            end
            S_LOAD: begin
                o_cpu_rst  = 1'b1;
                o_ld_ready = 1'b1;
                o_imem_we  = i_ld_valid;
                if (cmd_acc && i_cmd == CMD_ABORT) begin
                    next_state = S_IDLE;
                end else if (i_ld_valid && (i_ld_last || ld_addr == '1)) begin
                    next_state = S_IDLE;
                    done_set   = 1'b1;
                end
            end
            S_RUN: begin
                o_cpu_en = 1'b1;
                // ABORT outranks halt, halt outranks watchdog expiry.
                if (cmd_acc && i_cmd == CMD_ABORT) begin
                    next_state = S_IDLE;
                end else if (i_halt) begin
                    next_state = S_DONE;
                    done_set   = 1'b1;
                end
`ifdef BIP_WATCHDOG_EN
                else if (wd_cnt == WD_LAST) begin
                    next_state  = S_DONE;
                    done_set    = 1'b1;
                    timeout_set = 1'b1;
                end
`endif
            end
            S_STEP: begin
                o_cpu_en = 1'b1;
                if (i_halt) begin
                    next_state = S_DONE;
                    done_set   = 1'b1;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_DONE: begin
                if (cmd_acc && i_cmd == CMD_LOAD) begin
                    next_state = S_LOAD;
                    load_clr   = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            ld_addr <= '0;
            cycles  <= '0;
            done_q  <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= done_set;
            if (load_clr) begin
                ld_addr <= '0;
            end else if (state == S_LOAD && i_ld_valid && ld_addr != '1) begin
                // Address holds at the top entry instead of wrapping.
                ld_addr <= ld_addr + 1'b1;
            end
            if (load_clr) begin
                cycles <= '0;
            end else if (o_cpu_en && cycles != '1) begin
                cycles <= cycles + 1'b1;
            end
        end
    end

`ifdef BIP_WATCHDOG_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (run_start) begin
                wd_cnt <= '0;
            end else if (state == S_RUN) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (load_clr) begin
                timeout_q <= 1'b0;
            end else if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bip_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bip_run_ctrl
//
// Self-checking bench for bip_run_ctrl. Inputs are driven on the falling
// edge and outputs sampled 1 ns later, so each vector describes one full
// cycle: the inputs applied and the outputs expected during that cycle.
// A vector table covers load, run-to-halt, step, abort and ignored-command
// behaviour; hand-written sequences cover a full 2048-word load, reset in
// the middle of RUN and, when BIP_WATCHDOG_EN is defined, the watchdog.
// -----------------------------------------------------------------------------
module tb_bip_run_ctrl;

    localparam int BITS = 16;
    localparam int ADDR = BITS - 5;

    localparam logic [1:0] C_LOAD  = 2'b00;
    localparam logic [1:0] C_RUN   = 2'b01;
    localparam logic [1:0] C_STEP  = 2'b10;
    localparam logic [1:0] C_ABORT = 2'b11;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic [1:0]        cmd;
    logic              cmd_ready;
    logic              ld_valid;
    logic [BITS-1:0]   ld_word;
    logic              ld_last;
    logic              ld_ready;
    logic              halt;
    logic              cpu_en;
    logic              cpu_rst;
    logic              imem_we;
    logic [ADDR-1:0]   imem_addr;
    logic [BITS-1:0]   imem_wdata;
    logic [2:0]        state;
    logic [31:0]       cycles;
    logic              done;
    logic              timeout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bip_run_ctrl #(.BITS(BITS), .ADDR(ADDR), .WD_LIMIT(16)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cmd_valid (cmd_valid),
        .i_cmd       (cmd),
        .o_cmd_ready (cmd_ready),
        .i_ld_valid  (ld_valid),
        .i_ld_word   (ld_word),
        .i_ld_last   (ld_last),
        .o_ld_ready  (ld_ready),
        .i_halt      (halt),
        .o_cpu_en    (cpu_en),
        .o_cpu_rst   (cpu_rst),
        .o_imem_we   (imem_we),
        .o_imem_addr (imem_addr),
        .o_imem_wdata(imem_wdata),
        .o_state     (state),
        .o_cycles    (cycles),
        .o_done      (done),
        .o_timeout   (timeout)
    );

    typedef struct {
        logic        cv;
        logic [1:0]  cmd;
        logic        lv;
        logic [15:0] lw;
        logic        ll;
        logic        h;
        logic [2:0]  st;
        logic        cr;
        logic        lr;
        logic        we;
        logic [10:0] a;
        logic        en;
        logic        rs;
        logic        d;
        logic [31:0] c;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic cv, input logic [1:0] c_cmd, input logic lv,
        input logic [15:0] lw, input logic ll, input logic h,
        input logic [2:0] st, input logic cr, input logic lr, input logic we,
        input logic [10:0] a, input logic en, input logic rs, input logic d,
        input logic [31:0] c);
        vec_t v;
        v.cv = cv; v.cmd = c_cmd; v.lv = lv; v.lw = lw; v.ll = ll; v.h = h;
        v.st = st; v.cr = cr; v.lr = lr; v.we = we; v.a = a;
        v.en = en; v.rs = rs; v.d = d; v.c = c;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cv, input logic [1:0] c_cmd,
                         input logic lv, input logic [15:0] lw,
                         input logic ll, input logic h);
        @(negedge clk);
        cmd_valid = cv; cmd = c_cmd; ld_valid = lv; ld_word = lw;
        ld_last = ll; halt = h;
        #1;
    endtask

    task automatic idle_inputs();
        drive(1'b0, C_LOAD, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    // Watchdog guard: the bench must never hang.
    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int bad_addr;
        rst = 1'b1; cmd_valid = 1'b0; cmd = C_LOAD; ld_valid = 1'b0;
        ld_word = '0; ld_last = 1'b0; halt = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // {cv,cmd,lv,word,last,halt | state,cmd_rdy,ld_rdy,we,addr,en,cpu_rst,done,cycles}
        vecs.push_back(mk(0, C_LOAD,  0, 16'h0000, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)); // reset state
        vecs.push_back(mk(1, C_LOAD,  0, 16'h0000, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, C_LOAD,  1, 16'h0801, 0, 0, 1, 1, 1, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, C_LOAD,  0, 16'hFFFF, 0, 0, 1, 1, 1, 0, 1, 0, 1, 0, 0)); // bubble
        vecs.push_back(mk(1, C_RUN,   1, 16'h1002, 0, 0, 1, 1, 1, 1, 1, 0, 1, 0, 0)); // RUN ignored
        vecs.push_back(mk(0, C_LOAD,  1, 16'h0000, 1, 0, 1, 1, 1, 1, 2, 0, 1, 0, 0)); // last word
        vecs.push_back(mk(0, C_LOAD,  0, 16'h0000, 0, 0, 0, 1, 0, 0, 3, 0, 0, 1, 0)); // done pulse
        vecs.push_back(mk(1, C_RUN,   0, 16'h0000, 0, 0, 0, 1, 0, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, C_LOAD,  0, 16'h0000, 0, 0, 2, 1, 0, 0, 3, 1, 0, 0, 0));
        vecs.push_back(mk(0, C_LOAD,  0, 16'h0000, 0, 0, 2, 1, 0, 0, 3, 1, 0, 0, 1));
        vecs.push_back(mk(0, C_LOAD,  0, 16'h0000, 0, 1, 2, 1, 0, 0, 3, 1, 0, 0, 2)); // HLT
        vecs.push_back(mk(0, C_LOAD,  0, 16'h0000, 0, 0, 4, 1, 0, 0, 3, 0, 0, 1, 3)); // DONE
        vecs.push_back(mk(1, C_RUN,   0, 16'h0000, 0, 0, 4, 1, 0, 0, 3, 0, 0, 0, 3));
        vecs.push_back(mk(1, C_STEP,  0, 16'h0000, 0, 0, 4, 1, 0, 0, 3, 0, 0, 0, 3));
        vecs.push_back(mk(1, C_ABORT, 0, 16'h0000, 0, 0, 4, 1, 0, 0, 3, 0, 0, 0, 3));
        vecs.push_back(mk(1, C_LOAD,  0, 16'h0000, 0, 0, 4, 1, 0, 0, 3, 0, 0, 0, 3));
        vecs.push_back(mk(1, C_ABORT, 1, 16'h1234, 0, 0, 1, 1, 1, 1, 0, 0, 1, 0, 0)); // abort load
        vecs.push_back(mk(0, C_LOAD,  0, 16'h0000, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0)); // no done
        vecs.push_back(mk(1, C_STEP,  0, 16'h0000, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, C_RUN,   0, 16'h0000, 0, 0, 3, 0, 0, 0, 1, 1, 0, 0, 0)); // STEP, not ready
        vecs.push_back(mk(1, C_STEP,  0, 16'h0000, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, C_LOAD,  0, 16'h0000, 0, 0, 3, 0, 0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, C_RUN,   0, 16'h0000, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2));
        vecs.push_back(mk(0, C_LOAD,  0, 16'h0000, 0, 0, 2, 1, 0, 0, 1, 1, 0, 0, 2)); // resume
        vecs.push_back(mk(1, C_ABORT, 0, 16'h0000, 0, 1, 2, 1, 0, 0, 1, 1, 0, 0, 3)); // abort+halt
        vecs.push_back(mk(0, C_LOAD,  0, 16'h0000, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 4)); // no done
        vecs.push_back(mk(1, C_ABORT, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 4));
        vecs.push_back(mk(1, C_STEP,  0, 16'h0000, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 4));
        vecs.push_back(mk(0, C_LOAD,  0, 16'h0000, 0, 1, 3, 0, 0, 0, 1, 1, 0, 0, 4)); // step on HLT
        vecs.push_back(mk(0, C_LOAD,  0, 16'h0000, 0, 0, 4, 1, 0, 0, 1, 0, 0, 1, 5));
        vecs.push_back(mk(0, C_LOAD,  0, 16'h0000, 0, 0, 4, 1, 0, 0, 1, 0, 0, 0, 5));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].cv, vecs[i].cmd, vecs[i].lv, vecs[i].lw,
                  vecs[i].ll, vecs[i].h);
            check($sformatf("v%0d state", i),     32'(state),     32'(vecs[i].st));
            check($sformatf("v%0d cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].cr));
            check($sformatf("v%0d ld_ready", i),  32'(ld_ready),  32'(vecs[i].lr));
            check($sformatf("v%0d imem_we", i),   32'(imem_we),   32'(vecs[i].we));
            check($sformatf("v%0d imem_addr", i), 32'(imem_addr), 32'(vecs[i].a));
            check($sformatf("v%0d cpu_en", i),    32'(cpu_en),    32'(vecs[i].en));
            check($sformatf("v%0d cpu_rst", i),   32'(cpu_rst),   32'(vecs[i].rs));
            check($sformatf("v%0d done", i),      32'(done),      32'(vecs[i].d));
            check($sformatf("v%0d cycles", i),    cycles,         vecs[i].c);
            check($sformatf("v%0d timeout", i),   32'(timeout),   32'h0);
            if (vecs[i].we)
                check($sformatf("v%0d imem_wdata", i), 32'(imem_wdata), 32'(vecs[i].lw));
        end

        // Full-depth load without i_ld_last: must stop at 2047, no wrap.
        drive(1'b1, C_LOAD, 1'b0, 16'h0, 1'b0, 1'b0);   // accepted in DONE
        bad_addr = 0;
        for (int i = 0; i < 2048; i++) begin
            drive(1'b0, C_LOAD, 1'b1, 16'(i), 1'b0, 1'b0);
            if (imem_addr !== 11'(i) || imem_we !== 1'b1 || state !== 3'd1)
                bad_addr++;
        end
        check("full_load addr/we per word", 32'(bad_addr), 32'h0);
        drive(1'b0, C_LOAD, 1'b1, 16'hBEEF, 1'b0, 1'b0);  // extra word after end
        check("full_load state", 32'(state), 32'd0);
        check("full_load done",  32'(done), 32'h1);
        check("full_load we",    32'(imem_we), 32'h0);
        check("full_load addr",  32'(imem_addr), 32'd2047);
        check("full_load cycles", cycles, 32'd0);

        // Reset in the middle of RUN.
        drive(1'b1, C_RUN, 1'b0, 16'h0, 1'b0, 1'b0);
        idle_inputs();
        idle_inputs();
        check("mid_run state", 32'(state), 32'd2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst_run state",     32'(state),     32'd0);
        check("rst_run cycles",    cycles,         32'd0);
        check("rst_run cpu_en",    32'(cpu_en),    32'h0);
        check("rst_run cpu_rst",   32'(cpu_rst),   32'h0);
        check("rst_run cmd_ready", 32'(cmd_ready), 32'h1);
        check("rst_run addr",      32'(imem_addr), 32'h0);
        check("rst_run done",      32'(done),      32'h0);
        check("rst_run timeout",   32'(timeout),   32'h0);
        rst = 1'b0;

`ifdef BIP_WATCHDOG_EN
        // Looping program: watchdog ends RUN after 16 enabled cycles.
        drive(1'b1, C_LOAD, 1'b0, 16'h0, 1'b0, 1'b0);
        drive(1'b0, C_LOAD, 1'b1, 16'h5000, 1'b1, 1'b0);
        drive(1'b1, C_RUN, 1'b0, 16'h0, 1'b0, 1'b0);
        bad_addr = 0;
        for (int i = 0; i < 16; i++) begin
            idle_inputs();
            if (state !== 3'd2 || cpu_en !== 1'b1) bad_addr++;
        end
        check("wd run cycles enabled", 32'(bad_addr), 32'h0);
        idle_inputs();
        check("wd state",   32'(state),   32'd4);
        check("wd timeout", 32'(timeout), 32'h1);
        check("wd done",    32'(done),    32'h1);
        check("wd cycles",  cycles,       32'd16);
        drive(1'b1, C_LOAD, 1'b0, 16'h0, 1'b0, 1'b0);
        check("wd sticky",  32'(timeout), 32'h1);
        idle_inputs();
        check("wd cleared", 32'(timeout), 32'h0);
        check("wd load state", 32'(state), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
